hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core; companion to the forwarding logic.
- Decides every cycle which pipeline registers hold, flush or take a bubble. Covers load-use hazards that forwarding cannot resolve, taken-branch/jump redirects from EX, and multi-cycle data-memory waits via a ready handshake.
- Tracks memory-wait duration, traps on timeout, and keeps a stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register address width.
- MAX_MEM_WAIT, 15, maximum consecutive wait cycles before timeout; range 1..255.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rs1_IFID_addr  in  REG_ADDR_W  rs1 of instruction in ID.
- i_rs2_IFID_addr  in  REG_ADDR_W  rs2 of instruction in ID.
- i_rs1_used_IFID  in  1  ID instruction reads rs1.
- i_rs2_used_IFID  in  1  ID instruction reads rs2.
- i_is_store_IFID  in  1  ID instruction is a store.
- i_rd_waddr_IDEX  in  REG_ADDR_W  rd of instruction in EX.
- i_clu_MemRead_IDEX  in  1  EX instruction is a load.
- i_branch_taken_EX  in  1  EX redirects the PC (taken branch, JAL, JALR).
- i_dmem_req_EXMEM  in  1  MEM-stage instruction accesses data memory.
- i_dmem_ready  in  1  data memory completes the access this cycle.
- o_stall_PC  out  1  hold PC.
- o_stall_IFID  out  1  hold IF/ID.
- o_stall_IDEX  out  1  hold ID/EX.
- o_stall_EXMEM  out  1  hold EX/MEM.
- o_flush_IFID  out  1  clear IF/ID to NOP.
- o_flush_IDEX  out  1  clear ID/EX to NOP (bubble).
- o_bubble_MEMWB  out  1  write NOP into MEM/WB.
- o_mem_timeout  out  1  sticky trap flag.
- o_stall_count  out  PERF_W  saturating count of stall cycles.

Behaviour:
- All outputs except o_mem_timeout and o_stall_count are combinational (Mealy) from state and inputs. State, wait counter, timeout flag and perf counter are registered.
- While i_rst_n=0: state=RUN, wait_cnt=0, o_mem_timeout=0, o_stall_count=0. Combinational outputs are forced to o_flush_IFID=1, o_flush_IDEX=1, all others 0. Reset mid-wait abandons the wait with no other effect.

Decode terms:
- mem_stall = i_dmem_req_EXMEM & ~i_dmem_ready.
- lu1 = i_clu_MemRead_IDEX & rd!=0 & i_rs1_used_IFID & rd==rs1.
- lu2 = i_clu_MemRead_IDEX & rd!=0 & i_rs2_used_IFID & rd==rs2 & ~i_is_store_IFID. Store data is covered by MEM-to-MEM forwarding.
- load_use = lu1 | lu2.
- freeze means o_stall_PC, o_stall_IFID, o_stall_IDEX and o_stall_EXMEM are all 1, and o_bubble_MEMWB is 1.

States:
- RUN
  - Priority 1, mem_stall: freeze. Go to MEM_WAIT, wait_cnt<=1.
  - Priority 2, i_branch_taken_EX: o_flush_IFID=1, o_flush_IDEX=1, no stalls. A coincident load_use is ignored.
  - Priority 3, load_use: o_stall_PC=1, o_stall_IFID=1, o_flush_IDEX=1. This lasts exactly 1 cycle, because the load then moves to MEM.
  - Otherwise: all outputs 0.
- MEM_WAIT
  - If i_dmem_ready=1: evaluate the RUN rules with mem_stall=0 in the same cycle, then go to RUN, wait_cnt<=0.
  - Else if wait_cnt==MAX_MEM_WAIT: freeze, o_mem_timeout<=1, go to TRAP.
  - Else: freeze, wait_cnt<=wait_cnt+1.
  - i_branch_taken_EX is not acted on while frozen. It is acted on in the release cycle, because EX is held.
- TRAP: freeze every cycle. Exit only via reset. o_mem_timeout stays 1.

Perf counter:
- o_stall_count increments in any cycle where o_stall_PC=1.
- It saturates at all-ones and never wraps.

Other rules:
- Flush wins over stall on the same register. Never assert o_stall_IFID and o_flush_IFID together.
- Addresses compare on the full REG_ADDR_W bits. x0 never causes a hazard.

Decomposition:
- Shared core package: hazard_state_t enum {RUN, MEM_WAIT, TRAP}, NOP instruction constant, REG_ADDR_W default.
- One natural sub-module: hazard_loaduse_detect, purely combinational, produces load_use.
- FSM, wait counter and perf counter stay in hazard_ctrl.

Test Plan:
- Load-use: EX=LW x5, MemRead=1; ID=ADD x6,x5,x1 (rs1_used=1) -> one cycle of stall_PC=1, stall_IFID=1, flush_IDEX=1; next cycle all 0; stall_count=1.
- Store exemption and x0: EX=LW x5; ID=SW x5,0(x2) with rs2=5, rs1=2 -> no stall. Same with rd=x0 and rs1=0 -> no stall.
- Branch beats load-use: branch_taken_EX=1 with load_use=1 -> flush_IFID=1, flush_IDEX=1, stall_PC=0.
- Memory wait: dmem_req=1, ready=0 for 3 cycles, then 1 -> freeze for 3 cycles, release on cycle 4, state back to RUN, stall_count=3.
- Timeout: MAX_MEM_WAIT=4, ready held 0 -> after the 4th wait cycle o_mem_timeout=1 and outputs stay frozen. Pulse i_rst_n low -> timeout=0, state=RUN, outputs at reset values.
- Saturation: PERF_W=4, stall for 20 cycles -> o_stall_count=15 and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the canonical NOP instruction and default register-address width.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TRAP
  } hazard_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use detector: flags an ID-stage read of a register that
// the load currently in EX has not yet produced.
module hazard_loaduse_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic                  i_is_store,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_mem_read,
  output logic                  o_load_use
);

  logic w_rd_live;
  logic w_lu1;
  logic w_lu2;

  assign w_rd_live = i_mem_read && (i_rd_addr != '0);
  assign w_lu1     = w_rd_live && i_rs1_used && (i_rd_addr == i_rs1_addr);
  // Store data reaches MEM through MEM-to-MEM forwarding, so no stall needed.
  assign w_lu2     = w_rd_live && i_rs2_used && (i_rd_addr == i_rs2_addr) && !i_is_store;
  assign o_load_use = w_lu1 || w_lu2;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stalls,
// EX redirect flushes, data-memory wait freeze with timeout trap, stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int unsigned MAX_MEM_WAIT = 15,
  parameter int unsigned PERF_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_rs1_IFID_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_IFID_addr,
  input  logic                  i_rs1_used_IFID,
  input  logic                  i_rs2_used_IFID,
  input  logic                  i_is_store_IFID,
  input  logic [REG_ADDR_W-1:0] i_rd_waddr_IDEX,
  input  logic                  i_clu_MemRead_IDEX,
  input  logic                  i_branch_taken_EX,
  input  logic                  i_dmem_req_EXMEM,
  input  logic                  i_dmem_ready,
  output logic                  o_stall_PC,
  output logic                  o_stall_IFID,
  output logic                  o_stall_IDEX,
  output logic                  o_stall_EXMEM,
  output logic                  o_flush_IFID,
  output logic                  o_flush_IDEX,
  output logic                  o_bubble_MEMWB,
  output logic                  o_mem_timeout,
  output logic [PERF_W-1:0]     o_stall_count
);

  hazard_state_t     r_state;
  hazard_state_t     w_next_state;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        w_wait_next;
  logic              r_mem_timeout;
  logic              w_set_timeout;
  logic [PERF_W-1:0] r_stall_count;

  logic w_load_use;
  logic w_mem_stall;
  logic w_freeze;
  logic w_redirect;
  logic w_lu_stall;

  hazard_loaduse_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_loaduse (
    .i_rs1_addr (i_rs1_IFID_addr),
    .i_rs2_addr (i_rs2_IFID_addr),
    .i_rs1_used (i_rs1_used_IFID),
    .i_rs2_used (i_rs2_used_IFID),
    .i_is_store (i_is_store_IFID),
    .i_rd_addr  (i_rd_waddr_IDEX),
    .i_mem_read (i_clu_MemRead_IDEX),
    .o_load_use (w_load_use)
  );

  assign w_mem_stall = i_dmem_req_EXMEM && !i_dmem_ready;

  always_comb begin
    w_freeze      = 1'b0;
    w_redirect    = 1'b0;
    w_lu_stall    = 1'b0;
    w_set_timeout = 1'b0;
    w_next_state  = r_state;
    w_wait_next   = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_freeze     = 1'b1;
          w_next_state = MEM_WAIT;
          w_wait_next  = 8'd1;
        end else if (i_branch_taken_EX) begin
          w_redirect = 1'b1;
        end else if (w_load_use) begin
          w_lu_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Release cycle: EX was held, so the redirect/load-use it carries acts now.
        if (i_dmem_ready) begin
          w_next_state = RUN;
          w_wait_next  = '0;
          if (i_branch_taken_EX) begin
            w_redirect = 1'b1;
          end else if (w_load_use) begin
            w_lu_stall = 1'b1;
          end
        end else if (r_wait_cnt == 8'(MAX_MEM_WAIT)) begin
          w_freeze      = 1'b1;
          w_set_timeout = 1'b1;
          w_next_state  = TRAP;
        end else begin
          w_freeze    = 1'b1;
          w_wait_next = r_wait_cnt + 8'd1;
        end
      end
      TRAP: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_next_state = RUN;
        w_wait_next  = '0;
      end
    endcase

    o_stall_PC     = w_freeze || w_lu_stall;
    o_stall_IFID   = w_freeze || w_lu_stall;
    o_stall_IDEX   = w_freeze;
    o_stall_EXMEM  = w_freeze;
    o_flush_IFID   = w_redirect;
    o_flush_IDEX   = w_redirect || w_lu_stall;
    o_bubble_MEMWB = w_freeze;

    if (!i_rst_n) begin
      o_stall_PC     = 1'b0;
      o_stall_IFID   = 1'b0;
      o_stall_IDEX   = 1'b0;
      o_stall_EXMEM  = 1'b0;
      o_flush_IFID   = 1'b1;
      o_flush_IDEX   = 1'b1;
      o_bubble_MEMWB = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      if (w_set_timeout) begin
        r_mem_timeout <= 1'b1;
      end
      if (o_stall_PC && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + PERF_W'(1);
      end
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_MEM_WAIT=4, PERF_W=4).
module tb_hazard_ctrl;

  localparam int unsigned RW    = 5;
  localparam int unsigned PW    = 4;
  localparam int unsigned MAXW  = 4;

  // {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX, bubble_MEMWB}
  localparam logic [6:0] O_NONE   = 7'b0000_000;
  localparam logic [6:0] O_FREEZE = 7'b1111_001;
  localparam logic [6:0] O_LU     = 7'b1100_010;
  localparam logic [6:0] O_BR     = 7'b0000_110;
  localparam logic [6:0] O_RST    = 7'b0000_110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [RW-1:0] rs1, rs2, rd;
  logic          rs1_used, rs2_used, is_store, mem_read, br, req, rdy;
  logic          stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic          flush_ifid, flush_idex, bubble_memwb, mem_timeout;
  logic [PW-1:0] stall_count;
  logic [6:0]    outs;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_cnt  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W   (RW),
    .MAX_MEM_WAIT (MAXW),
    .PERF_W       (PW)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_rs1_IFID_addr    (rs1),
    .i_rs2_IFID_addr    (rs2),
    .i_rs1_used_IFID    (rs1_used),
    .i_rs2_used_IFID    (rs2_used),
    .i_is_store_IFID    (is_store),
    .i_rd_waddr_IDEX    (rd),
    .i_clu_MemRead_IDEX (mem_read),
    .i_branch_taken_EX  (br),
    .i_dmem_req_EXMEM   (req),
    .i_dmem_ready       (rdy),
    .o_stall_PC         (stall_pc),
    .o_stall_IFID       (stall_ifid),
    .o_stall_IDEX       (stall_idex),
    .o_stall_EXMEM      (stall_exmem),
    .o_flush_IFID       (flush_ifid),
    .o_flush_IDEX       (flush_idex),
    .o_bubble_MEMWB     (bubble_memwb),
    .o_mem_timeout      (mem_timeout),
    .o_stall_count      (stall_count)
  );

  assign outs = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, bubble_memwb};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [RW-1:0] a1, input logic u1, input logic [RW-1:0] a2,
                        input logic u2, input logic st, input logic [RW-1:0] d,
                        input logic mr, input logic b, input logic rq, input logic ry);
    rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2; is_store = st;
    rd = d; mem_read = mr; br = b; req = rq; rdy = ry;
  endtask

  // Called at a negedge with inputs set: checks Mealy outputs, clocks once,
  // then checks the perf counter against a saturating expected count.
  task automatic cycle(input string tag, input logic [6:0] exp_o);
    #1;
    check_eq({tag, "_outs"}, 32'(outs), 32'(exp_o));
    @(posedge clk);
    if (exp_o[6] && exp_cnt < 15) exp_cnt++;
    #1;
    check_eq({tag, "_cnt"}, 32'(stall_count), exp_cnt);
    @(negedge clk);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_outs", 32'(outs), 32'(O_RST));
    check_eq("rst_timeout", 32'(mem_timeout), 0);
    check_eq("rst_cnt", 32'(stall_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID
    set_in(5, 1, 1, 1, 0, 5, 1, 0, 0, 0);
    cycle("lu_rs1", O_LU);
    set_in(5, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle("lu_after", O_NONE);

    // Store data exemption, then rs2 hazard for a non-store
    set_in(2, 1, 5, 1, 1, 5, 1, 0, 0, 0);
    cycle("store_exempt", O_NONE);
    set_in(2, 1, 5, 1, 0, 5, 1, 0, 0, 0);
    cycle("lu_rs2", O_LU);
    set_in(0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    cycle("x0_nohaz", O_NONE);
    set_in(5'b00101, 1, 1, 1, 0, 5'b10101, 1, 0, 0, 0);
    cycle("fulladdr", O_NONE);
    set_in(5, 1, 5, 1, 0, 5, 0, 0, 0, 0);
    cycle("no_memread", O_NONE);

    // Branch beats load-use
    set_in(5, 1, 1, 1, 0, 5, 1, 1, 0, 0);
    cycle("br_over_lu", O_BR);

    // Memory wait of 3 cycles then release
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("mw1", O_FREEZE);
    cycle("mw2", O_FREEZE);
    cycle("mw3", O_FREEZE);
    rdy = 1'b1;
    cycle("mw_release", O_NONE);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("mw_idle", O_NONE);

    // Branch held during freeze acts on release
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle("mw_br_frozen", O_FREEZE);
    rdy = 1'b1;
    cycle("mw_br_release", O_BR);
    // Load-use held during freeze stalls on release
    set_in(7, 1, 0, 0, 0, 7, 1, 0, 1, 0);
    cycle("mw_lu_frozen", O_FREEZE);
    rdy = 1'b1;
    cycle("mw_lu_release", O_LU);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("post_mw", O_NONE);
    check_eq("no_timeout", 32'(mem_timeout), 0);

    // Timeout: wait_cnt reaches 4 on the 4th edge, trap taken on the 5th
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle($sformatf("to_wait%0d", i), O_FREEZE);
      check_eq($sformatf("to_pending%0d", i), 32'(mem_timeout), 0);
    end
    cycle("to_trap", O_FREEZE);
    check_eq("to_set", 32'(mem_timeout), 1);

    // TRAP ignores ready and branches; counter saturates
    set_in(5, 1, 0, 0, 0, 5, 1, 1, 1, 1);
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("trap%0d", i), O_FREEZE);
    end
    check_eq("sat_cnt", 32'(stall_count), 15);
    check_eq("trap_sticky", 32'(mem_timeout), 1);

    // Reset clears trap
    rst_n = 1'b0;
    #1;
    check_eq("rst2_outs", 32'(outs), 32'(O_RST));
    check_eq("rst2_timeout", 32'(mem_timeout), 0);
    check_eq("rst2_cnt", 32'(stall_count), 0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("rst2_run_br", O_BR);
    set_in(3, 1, 0, 0, 0, 3, 1, 0, 0, 0);
    cycle("rst2_lu", O_LU);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
